// File: rtl/fht_result_reader.sv
// Streams a finished FHT frame out of the 4-bank result RAM set in direct order (k = 0..N-1).
// Reads are credit-limited so that the small output FIFO absorbs the bank read latency without ever overflowing.
module fht_result_reader #(
  parameter int A_BIT      = 8,
  parameter int D_BIT      = 16,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iFHT_RDY,
  input  logic             iRES_SET,
  output logic             oSET_SEL,
  output logic             oRD_EN,
  output logic [A_BIT-1:0] oADDR_RD,
  output logic [1:0]       oBANK_RD,
  input  logic [D_BIT-1:0] iDATA_0,
  input  logic [D_BIT-1:0] iDATA_1,
  input  logic [D_BIT-1:0] iDATA_2,
  input  logic [D_BIT-1:0] iDATA_3,
  output logic [D_BIT-1:0] oDATA,
  output logic             oVALID,
  input  logic             iREADY,
  output logic             oSOP,
  output logic             oEOP,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oOVERRUN
);

  localparam int K_W   = A_BIT + 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int E_W   = D_BIT + 2;

  localparam logic [K_W-1:0]   K_LAST   = '1;
  localparam logic [CNT_W:0]   DEPTH_L  = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic       vld;
    logic       sop;
    logic       eop;
    logic [1:0] bank;
  } stage_t;

  state_t           state_reg, state_next;
  logic             rdy_d_reg;
  logic [K_W-1:0]   k_reg, k_next;
  logic             set_sel_reg, set_sel_next;
  logic             overrun_reg, overrun_next;
  logic             done_reg, done_next;
  logic             start;
  logic             issue;
  logic             accept;
  logic [CNT_W:0]   in_flight;
  logic [CNT_W:0]   occupancy;

  stage_t           pipe_reg  [RD_LAT];
  stage_t           pipe_next [RD_LAT];
  stage_t           cap;
  logic [D_BIT-1:0] cap_data;

  logic [E_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] fifo_cnt_reg;
  logic [E_W-1:0]   fifo_head;

  // rdy_d resets high so a ready flag already asserted out of reset is not an edge
  assign start  = iFHT_RDY & ~rdy_d_reg;
  assign accept = oVALID & iREADY;

  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    set_sel_next = set_sel_reg;
    overrun_next = overrun_reg | (start & (state_reg != S_IDLE));
    done_next    = 1'b0;
    issue        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next   = S_READ;
          k_next       = '0;
          set_sel_next = iRES_SET;
        end
      end
      S_READ: begin
        if (occupancy < DEPTH_L) begin
          issue  = 1'b1;
          k_next = k_reg + 1'b1;
          if (k_reg == K_LAST) begin
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (accept && oEOP) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_reg   <= S_IDLE;
      rdy_d_reg   <= 1'b1;
      k_reg       <= '0;
      set_sel_reg <= 1'b0;
      overrun_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rdy_d_reg   <= iFHT_RDY;
      k_reg       <= k_next;
      set_sel_reg <= set_sel_next;
      overrun_reg <= overrun_next;
      done_reg    <= done_next;
    end
  end

  // Tag pipeline runs in lockstep with the bank RAM read latency
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      assign pipe_next[gi] = '{vld:  issue,
                               sop:  issue && (k_reg == '0),
                               eop:  issue && (k_reg == K_LAST),
                               bank: k_reg[1:0]};
    end else begin : g_tail
      assign pipe_next[gi] = pipe_reg[gi-1];
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_reg[i] <= '0;
      end
    end else begin
      pipe_reg <= pipe_next;
    end
  end

  // Every outstanding read plus every stored word holds one FIFO slot
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      in_flight = in_flight + (CNT_W+1)'(pipe_reg[i].vld);
    end
  end

  assign occupancy = in_flight + {1'b0, fifo_cnt_reg};
  assign cap       = pipe_reg[RD_LAT-1];

  always_comb begin
    cap_data = iDATA_0;
    case (cap.bank)
      2'd0:    cap_data = iDATA_0;
      2'd1:    cap_data = iDATA_1;
      2'd2:    cap_data = iDATA_2;
      default: cap_data = iDATA_3;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (cap.vld) begin
        fifo_mem[wr_ptr_reg] <= {cap.eop, cap.sop, cap_data};
        wr_ptr_reg           <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (accept) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({cap.vld, accept})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  assign fifo_head = fifo_mem[rd_ptr_reg];

  assign oVALID   = (fifo_cnt_reg != '0);
  assign oDATA    = fifo_head[D_BIT-1:0];
  assign oSOP     = fifo_head[D_BIT];
  assign oEOP     = fifo_head[D_BIT+1];
  assign oRD_EN   = issue;
  assign oADDR_RD = k_reg[K_W-1:2];
  assign oBANK_RD = k_reg[1:0];
  assign oSET_SEL = set_sel_reg;
  assign oBUSY    = (state_reg != S_IDLE);
  assign oDONE    = done_reg;
  assign oOVERRUN = overrun_reg;

endmodule

// File: tb/tb_fht_result_reader.sv
// Directed bench for fht_result_reader: a table of whole-frame scenarios plus hand sequences
// for reset-held ready, mid-frame reset and restart on the other RAM set.
module tb_fht_result_reader;

  localparam int A_BIT = 8;
  localparam int D_BIT = 16;
  localparam int N     = 1024;

  logic             iCLK = 1'b0;
  logic             iRESET = 1'b1;
  logic             iFHT_RDY = 1'b0;
  logic             iRES_SET = 1'b0;
  logic             iREADY = 1'b0;
  logic             oSET_SEL, oRD_EN, oVALID, oSOP, oEOP, oBUSY, oDONE, oOVERRUN;
  logic [A_BIT-1:0] oADDR_RD;
  logic [1:0]       oBANK_RD;
  logic [D_BIT-1:0] iDATA_0, iDATA_1, iDATA_2, iDATA_3, oDATA;

  int checks = 0;
  int errors = 0;

  fht_result_reader #(.A_BIT(8), .D_BIT(16), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iFHT_RDY(iFHT_RDY), .iRES_SET(iRES_SET),
    .oSET_SEL(oSET_SEL), .oRD_EN(oRD_EN), .oADDR_RD(oADDR_RD), .oBANK_RD(oBANK_RD),
    .iDATA_0(iDATA_0), .iDATA_1(iDATA_1), .iDATA_2(iDATA_2), .iDATA_3(iDATA_3),
    .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY), .oSOP(oSOP), .oEOP(oEOP),
    .oBUSY(oBUSY), .oDONE(oDONE), .oOVERRUN(oOVERRUN)
  );

  always #5 iCLK = ~iCLK;

  // Bank RAM model: set A bank b addr a holds 4a+b, set B holds its complement; 2-cycle read latency
  function automatic logic [15:0] ram_word(input logic s, input logic [1:0] b, input logic [7:0] a);
    logic [15:0] w;
    w = {6'd0, a, b};
    return s ? ~w : w;
  endfunction

  logic [7:0] a_d1, a_d2;
  logic       s_d1, s_d2;
  always @(posedge iCLK) begin
    a_d1 <= oADDR_RD;
    s_d1 <= oSET_SEL;
    a_d2 <= a_d1;
    s_d2 <= s_d1;
  end
  assign iDATA_0 = ram_word(s_d2, 2'd0, a_d2);
  assign iDATA_1 = ram_word(s_d2, 2'd1, a_d2);
  assign iDATA_2 = ram_word(s_d2, 2'd2, a_d2);
  assign iDATA_3 = ram_word(s_d2, 2'd3, a_d2);

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRESET = 1'b1;
    @(negedge iCLK);
    chk("reset_ctrl", {oSET_SEL, oRD_EN, oVALID, oSOP, oEOP, oBUSY, oDONE, oOVERRUN, oADDR_RD, oBANK_RD}, 0);
    chk("reset_data", oDATA, 0);
    iRESET = 1'b0;
  endtask

  // mode 0: iREADY high, 1: random 50%, 2: low for the first 100 cycles after the start edge
  task automatic run_frame(input string name, input logic res_set, input int mode, input int ovr_word,
                           input int abort_word, input int exp_lat, input int exp_rd_early,
                           input logic exp_ovr);
    int cyc = 0, words = 0, issued = 0, dones = 0, done_cyc = 0, rd_early = 0;
    int max_out = 0, gaps = 0, first_vld = 0;
    logic prev_hold = 1'b0;
    logic [17:0] prev_head = '0;
    logic [15:0] w16, exp_d;
    iFHT_RDY = 1'b0;
    iREADY   = 1'b0;
    repeat (3) @(negedge iCLK);
    iRES_SET = res_set;
    iFHT_RDY = 1'b1;
    while (cyc < 5000) begin
      @(negedge iCLK);
      cyc++;
      case (mode)
        0:       iREADY = 1'b1;
        1:       iREADY = 1'($urandom_range(0, 1));
        default: iREADY = (cyc > 100);
      endcase
      if (ovr_word >= 0) begin
        if (words == ovr_word - 100) iFHT_RDY = 1'b0;
        if (words == ovr_word) begin
          iFHT_RDY = 1'b1;
          iRES_SET = ~res_set;
        end
      end
      if (cyc == 1) chk("first_rd_en", oRD_EN, 1);
      if (cyc == 10) begin
        chk("set_sel_mid", oSET_SEL, res_set);
        chk("busy_mid", oBUSY, 1);
      end
      if (oRD_EN) begin
        issued++;
        if (cyc <= 100) rd_early++;
      end
      if (issued - words > max_out) max_out = issued - words;
      if (oVALID && first_vld == 0) first_vld = cyc;
      if (prev_hold) begin
        chk("hold_valid", oVALID, 1);
        chk("hold_head", {oEOP, oSOP, oDATA}, prev_head);
      end
      if (mode != 1 && words > 0 && words < N && iREADY && !oVALID) gaps++;
      if (oVALID && iREADY) begin
        w16   = 16'(words);
        exp_d = res_set ? ~w16 : w16;
        chk("data", oDATA, exp_d);
        chk("sop", oSOP, words == 0);
        chk("eop", oEOP, words == N - 1);
        words++;
      end
      prev_hold = oVALID & ~iREADY;
      prev_head = {oEOP, oSOP, oDATA};
      if (oDONE) begin
        dones++;
        if (dones == 1) begin
          done_cyc = cyc;
          chk("busy_at_done", oBUSY, 0);
          chk("words_at_done", words, N);
        end
      end
      if (abort_word >= 0 && words == abort_word) begin
        $display("frame %s: aborted after %0d words at cycle %0d", name, words, cyc);
        return;
      end
      if (dones > 0 && cyc >= done_cyc + 10) break;
    end
    chk("done_count", dones, 1);
    chk("word_count", words, N);
    chk("read_count", issued, N);
    chk("first_valid_cyc", first_vld, 4);
    chk("no_gaps", gaps, 0);
    chk("credit_limit", max_out <= 4, 1);
    chk("busy_after", oBUSY, 0);
    chk("set_sel_end", oSET_SEL, res_set);
    chk("overrun", oOVERRUN, exp_ovr);
    if (exp_lat != 0) chk("done_latency", done_cyc, exp_lat);
    if (exp_rd_early >= 0) chk("early_reads", rd_early, exp_rd_early);
    $display("frame %s: words=%0d reads=%0d done_cyc=%0d early_reads=%0d overrun=%0d",
             name, words, issued, done_cyc, rd_early, oOVERRUN);
  endtask

  typedef struct {
    string name;
    logic  res_set;
    int    mode;
    int    ovr_word;
    int    exp_lat;
    int    exp_rd_early;
    logic  exp_ovr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int rd_cnt, busy_cnt;
    vecs[0] = '{"ramp_ready", 1'b0, 0, -1, 1028, 100, 1'b0};
    vecs[1] = '{"random_ready", 1'b0, 1, -1, 0, -1, 1'b0};
    vecs[2] = '{"stall_100", 1'b0, 2, -1, 1125, 4, 1'b0};
    vecs[3] = '{"overrun_500", 1'b1, 0, 500, 1028, 100, 1'b1};

    // Ready already high out of reset must not start a frame
    iFHT_RDY = 1'b1;
    do_reset();
    rd_cnt = 0;
    busy_cnt = 0;
    repeat (50) begin
      @(negedge iCLK);
      if (oRD_EN) rd_cnt++;
      if (oBUSY) busy_cnt++;
    end
    chk("no_edge_rd_en", rd_cnt, 0);
    chk("no_edge_busy", busy_cnt, 0);
    $display("seq ready_high_from_reset: rd_en=%0d busy=%0d", rd_cnt, busy_cnt);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      run_frame(vecs[i].name, vecs[i].res_set, vecs[i].mode, vecs[i].ovr_word, -1,
                vecs[i].exp_lat, vecs[i].exp_rd_early, vecs[i].exp_ovr);
    end

    // Reset at word 300, then restart on set B
    do_reset();
    run_frame("pre_reset", 1'b0, 0, -1, 300, 0, -1, 1'b0);
    do_reset();
    run_frame("after_reset_setB", 1'b1, 0, -1, -1, 1028, 100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
